// File: rtl/smc_unit_arbiter.sv
// Round-robin arbiter that shares one pipelined smc_float unit between NUM_REQ requesters.
// A tag pipe matched to the unit latency routes each result back to the requester that issued it.
module smc_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 6,
   parameter int TAG_W   = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_x_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_y_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [DATA_W-1:0]         unit_x_o,
   output logic [DATA_W-1:0]         unit_y_o,
   output logic                      unit_srdyi_o,
   input  logic [DATA_W-1:0]         unit_z_i,
   input  logic                      unit_srdyo_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_z_o,
   output logic                      busy_o,
   output logic                      err_o
);

   logic [DATA_W-1:0]              x_q, x_d;
   logic [DATA_W-1:0]              y_q, y_d;
   logic                           srdyi_q, srdyi_d;
   logic [TAG_W-1:0]               issue_tag_q, issue_tag_d;
   logic [TAG_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic [LATENCY-1:0]             tag_vld_q, tag_vld_d;
   logic [LATENCY-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]              rsp_z_q, rsp_z_d;
   logic                           err_q, err_d;

   logic                           win_vld;
   logic [TAG_W-1:0]               win_idx;
   logic [TAG_W:0]                 scan_sum;
   logic                           tail_vld;
   logic [TAG_W-1:0]               tail_tag;

   // Scan from rr_ptr upward with wrap; iterating from the far end lets the nearest requester win.
   // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      scan_sum = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         scan_sum = {1'b0, rr_ptr_q} + (TAG_W + 1)'(i);
         if (scan_sum >= (TAG_W + 1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (TAG_W + 1)'(NUM_REQ);
         end
         if (req_i[scan_sum[TAG_W-1:0]]) begin
            win_vld = 1'b1;
            win_idx = scan_sum[TAG_W-1:0];
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (win_vld && !reset) begin
         gnt_o[win_idx] = 1'b1;
      end
   end

   assign tail_vld = tag_vld_q[LATENCY-1];
   assign tail_tag = tag_q[LATENCY-1];

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      srdyi_d     = win_vld;
      issue_tag_d = issue_tag_q;
      rr_ptr_d    = rr_ptr_q;
      if (win_vld) begin
         x_d         = req_x_i[int'(win_idx) * DATA_W +: DATA_W];
         y_d         = req_y_i[int'(win_idx) * DATA_W +: DATA_W];
         issue_tag_d = win_idx;
         rr_ptr_d    = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + TAG_W'(1);
      end

      // Stage 0 loads while unit_srdyi_o is high, so the tail is valid exactly when srdyo is due.
      tag_vld_d[0] = srdyi_q;
      tag_d[0]     = issue_tag_q;
      for (int s = 1; s < LATENCY; s++) begin
         tag_vld_d[s] = tag_vld_q[s-1];
         tag_d[s]     = tag_q[s-1];
      end

      rsp_valid_d = '0;
      rsp_z_d     = rsp_z_q;
      if (unit_srdyo_i && tail_vld) begin
         rsp_z_d               = unit_z_i;
         rsp_valid_d[tail_tag] = 1'b1;
      end
      err_d = err_q | (unit_srdyo_i ^ tail_vld);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q         <= '0;
         y_q         <= '0;
         srdyi_q     <= 1'b0;
         issue_tag_q <= '0;
         rr_ptr_q    <= '0;
         tag_vld_q   <= '0;
         rsp_valid_q <= '0;
         rsp_z_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         srdyi_q     <= srdyi_d;
         issue_tag_q <= issue_tag_d;
         rr_ptr_q    <= rr_ptr_d;
         tag_vld_q   <= tag_vld_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_z_q     <= rsp_z_d;
         err_q       <= err_d;
      end
   end

   // NOTE: tag payloads are only read when their valid bit is set, so they carry no reset.
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

   assign unit_x_o     = x_q;
   assign unit_y_o     = y_q;
   assign unit_srdyi_o = srdyi_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_z_o      = rsp_z_q;
   assign err_o        = err_q;
   assign busy_o       = srdyi_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_smc_unit_arbiter.sv
// Directed bench for smc_unit_arbiter with a behavioural 6-cycle multiplier as the shared unit.
// Expected responses are queued at issue time and checked by an independent monitor.
module tb_smc_unit_arbiter;

   localparam int NR  = 4;
   localparam int DW  = 32;
   localparam int LAT = 6;
   localparam int TW  = 2;

   typedef struct {
      logic [NR-1:0] onehot;
      logic [DW-1:0] z;
      int            cyc;
   } sb_entry_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NR-1:0]     req_i = '1;
   logic [NR*DW-1:0]  req_x_i;
   logic [NR*DW-1:0]  req_y_i;
   logic [NR-1:0]     gnt_o;
   logic [DW-1:0]     unit_x_o;
   logic [DW-1:0]     unit_y_o;
   logic              unit_srdyi_o;
   logic [DW-1:0]     unit_z_i;
   logic              unit_srdyo_i;
   logic [NR-1:0]     rsp_valid_o;
   logic [DW-1:0]     rsp_z_o;
   logic              busy_o;
   logic              err_o;

   logic [DW-1:0]     op_x [NR];
   logic [DW-1:0]     op_y [NR];
   logic              inject = 1'b0;
   logic [LAT-1:0]    mu_v;
   logic [DW-1:0]     mu_z [LAT];

   sb_entry_t         sb[$];
   int                cyc = 0;
   int                n_vec = 0;
   int                n_fail = 0;
   int                rsp_seen = 0;

   smc_unit_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT), .TAG_W(TW)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_i        (req_i),
      .req_x_i      (req_x_i),
      .req_y_i      (req_y_i),
      .gnt_o        (gnt_o),
      .unit_x_o     (unit_x_o),
      .unit_y_o     (unit_y_o),
      .unit_srdyi_o (unit_srdyi_o),
      .unit_z_i     (unit_z_i),
      .unit_srdyo_i (unit_srdyo_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_z_o      (rsp_z_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar r = 0; r < NR; r++) begin : g_pack
      assign req_x_i[r*DW +: DW] = op_x[r];
      assign req_y_i[r*DW +: DW] = op_y[r];
   end

   // Stand-in unit: integer multiply, fixed latency, same reset as the arbiter.
   always @(posedge clk) begin
      if (reset) begin
         mu_v <= '0;
      end else begin
         mu_v <= {mu_v[LAT-2:0], unit_srdyi_o};
      end
      for (int i = LAT - 1; i > 0; i--) mu_z[i] <= mu_z[i-1];
      mu_z[0] <= unit_x_o * unit_y_o;
   end
   assign unit_srdyo_i = mu_v[LAT-1] | inject;
   assign unit_z_i     = mu_z[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && rsp_valid_o != '0) begin
         rsp_seen++;
         if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid_o), 32'h0);
         end else begin
            sb_entry_t e;
            e = sb.pop_front();
            check("rsp_onehot", 32'(rsp_valid_o), 32'(e.onehot));
            check("rsp_z", rsp_z_o, e.z);
            check("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle: present req, check the combinational grant, optionally queue the response.
   task automatic drive(input logic [NR-1:0] req, input logic [NR-1:0] exp_gnt,
                        input logic [DW-1:0] exp_z, input bit push, input string name);
      sb_entry_t e;
      req_i = req;
      #1;
      check(name, 32'(gnt_o), 32'(exp_gnt));
      if (push && exp_gnt != '0) begin
         e.onehot = exp_gnt;
         e.z      = exp_z;
         e.cyc    = cyc + 8;
         sb.push_back(e);
      end
      step();
   endtask

   task automatic drain();
      int k;
      k = 0;
      req_i = '0;
      while (sb.size() != 0 && k < 60) begin
         step();
         k++;
      end
      check("drain_queue_empty", sb.size(), 0);
   endtask

   task automatic apply_reset();
      req_i = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [DW-1:0] all4_z [NR];
      logic [NR-1:0] g;
      all4_z = '{32'd2, 32'd34, 32'd66, 32'd98};
      for (int r = 0; r < NR; r++) begin
         op_x[r] = '0;
         op_y[r] = '0;
      end

      // Reset: grants suppressed while reset is high, all registers at reset values afterwards.
      step();
      step();
      check("gnt_in_reset", 32'(gnt_o), 32'h0);
      reset = 1'b0;
      req_i = '0;
      check("rst_srdyi", 32'(unit_srdyi_o), 32'h0);
      check("rst_unit_x", unit_x_o, 32'h0);
      check("rst_unit_y", unit_y_o, 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      check("rst_rsp_z", rsp_z_o, 32'h0);
      check("rst_err", 32'(err_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);

      // Single requester: 3 * 5 through requester 2.
      op_x[2] = 32'h3;
      op_y[2] = 32'h5;
      n = cyc;
      drive(4'b0100, 4'b0100, 32'h0000000F, 1'b1, "single_gnt");
      check("single_srdyi", 32'(unit_srdyi_o), 32'h1);
      check("single_unit_x", unit_x_o, 32'h3);
      check("single_unit_y", unit_y_o, 32'h5);
      check("single_busy", 32'(busy_o), 32'h1);
      while (cyc < n + 9) drive(4'b0000, 4'b0000, '0, 1'b0, "single_idle_gnt");
      check("single_busy_low", 32'(busy_o), 32'h0);
      drain();

      // All four requesting continuously: strict 0,1,2,3 rotation, one grant per cycle.
      apply_reset();
      for (int r = 0; r < NR; r++) begin
         op_x[r] = 32'(r * 16 + 1);
         op_y[r] = 32'd2;
      end
      for (int k = 0; k < 8; k++) begin
         g = '0;
         g[k % NR] = 1'b1;
         drive(4'b1111, g, all4_z[k % NR], 1'b1, "all4_gnt");
      end
      drain();

      // Fairness: 0 and 3 alternate.
      apply_reset();
      op_x[0] = 32'd7;  op_y[0] = 32'd9;
      op_x[3] = 32'd11; op_y[3] = 32'd13;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) drive(4'b1001, 4'b0001, 32'd63, 1'b1, "fair_gnt0");
         else            drive(4'b1001, 4'b1000, 32'd143, 1'b1, "fair_gnt3");
      end
      drain();

      // Idle gaps: requester 1 at relative cycles 0, 3 and 4.
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         check("gap_srdyi", 32'(unit_srdyi_o), (i == 1 || i == 4 || i == 5) ? 32'h1 : 32'h0);
         if (i == 0) begin
            op_x[1] = 32'd2; op_y[1] = 32'd3;
            drive(4'b0010, 4'b0010, 32'd6, 1'b1, "gap_gnt");
         end else if (i == 3) begin
            op_x[1] = 32'd4; op_y[1] = 32'd5;
            drive(4'b0010, 4'b0010, 32'd20, 1'b1, "gap_gnt");
         end else if (i == 4) begin
            op_x[1] = 32'd6; op_y[1] = 32'd7;
            drive(4'b0010, 4'b0010, 32'd42, 1'b1, "gap_gnt");
         end else begin
            drive(4'b0000, 4'b0000, '0, 1'b0, "gap_idle_gnt");
         end
      end
      drain();

      // Reset mid-flight: three issues discarded, pointer back to 0.
      apply_reset();
      drive(4'b0111, 4'b0001, '0, 1'b0, "mf_gnt0");
      drive(4'b0111, 4'b0010, '0, 1'b0, "mf_gnt1");
      drive(4'b0111, 4'b0100, '0, 1'b0, "mf_gnt2");
      drive(4'b0000, 4'b0000, '0, 1'b0, "mf_idle_gnt");
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mf_busy", 32'(busy_o), 32'h0);
      check("mf_err", 32'(err_o), 32'h0);
      n = rsp_seen;
      for (int k = 0; k < 12; k++) drive(4'b0000, 4'b0000, '0, 1'b0, "mf_quiet_gnt");
      check("mf_no_rsp", rsp_seen, n);
      check("mf_err_after", 32'(err_o), 32'h0);
      op_x[1] = 32'd9; op_y[1] = 32'd10;
      drive(4'b1010, 4'b0010, 32'd90, 1'b1, "mf_next_gnt");
      drain();

      // Protocol fault: stray srdyo with nothing in flight sets the sticky error.
      for (int k = 0; k < 3; k++) step();
      check("fault_pre_busy", 32'(busy_o), 32'h0);
      check("fault_pre_err", 32'(err_o), 32'h0);
      inject = 1'b1;
      step();
      inject = 1'b0;
      check("fault_err", 32'(err_o), 32'h1);
      check("fault_rsp_valid", 32'(rsp_valid_o), 32'h0);
      for (int k = 0; k < 3; k++) step();
      check("fault_err_sticky", 32'(err_o), 32'h1);
      check("fault_rsp_quiet", 32'(rsp_valid_o), 32'h0);

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
